// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path widths, reset PC and buffer entry type
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int ROM_AW = 7;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry {pc, instr} buffer, head always in slot 0, flush clears
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] din_pc,
    input  logic [XLEN-1:0] din_instr,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr,
    output logic [1:0]      count
);
    fetch_entry_t mem [2];
    logic [1:0] slot;
    assign slot = count - {1'b0, pop};
    assign head_pc = mem[0].pc;
    assign head_instr = mem[0].instr;
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count <= '0;
        end else begin
            assert (count <= 2'd2);
            assert (!(push && !pop && count == 2'd2));
            assert (!(pop && count == 2'd0));
            // shift on pop; the push lands behind whatever remains
            if (pop) mem[0] <= mem[1];
            if (push) mem[slot[0]] <= {din_pc, din_instr};
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner driving a 1-cycle-latency ROM into a 2-entry decode buffer
module fetch_unit
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [XLEN-1:0]   rom_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_instr,
    output logic [XLEN-1:0]   if_pc,
    input  logic              if_ready
);
    logic [XLEN-1:0] pc, inflight_pc, head_pc, head_instr;
    logic            inflight, live, pop;
    logic [1:0]      count;
    logic [2:0]      occ;
    assign rom_addr = pc[ROM_AW+1:2];
    assign if_valid = rst_n & (count != 2'd0);
    assign if_instr = if_valid ? head_instr : '0;
    assign if_pc = if_valid ? head_pc : '0;
    assign pop = if_valid & if_ready;
    // only issue when the returning word is guaranteed a buffer slot
    assign occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign rom_en = rst_n & live & ~redirect_valid & (occ < 3'd2);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            inflight <= 1'b0;
            inflight_pc <= '0;
            live <= 1'b0;
        end else begin
            live <= 1'b1;
            if (redirect_valid) begin
                pc <= redirect_pc & ~XLEN'(3);
                inflight <= 1'b0;
            end else begin
                inflight <= rom_en;
                if (rom_en) begin
                    inflight_pc <= pc;
                    pc <= pc + XLEN'(4);
                end
            end
        end
    end
    fetch_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight),
        .pop        (pop),
        .flush      (redirect_valid),
        .din_pc     (inflight_pc),
        .din_instr  (rom_data),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fill, stall, redirect, wrap and mid-stream reset
module tb_fetch_unit;
    import cpu_pkg::*;
    logic              clk = 1'b0;
    logic              rst_n, rom_en, redirect_valid, if_valid, if_ready;
    logic [ROM_AW-1:0] rom_addr;
    logic [XLEN-1:0]   rom_data, redirect_pc, if_instr, if_pc;
    logic [XLEN-1:0]   rom [128];
    int                vectors = 0;
    int                errs = 0;
    int                exp_n;

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        chk({tag, "_valid"}, if_valid, 1'b1);
        chk({tag, "_pc"}, if_pc, pc);
        chk({tag, "_instr"}, if_instr, instr);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        tick;
        tick;
        rst_n = 1'b1;
        settle;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = i;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        if_ready = 1'b1;
        tick;
        tick;
        chk("rst_rom_en", rom_en, 1'b0);
        chk("rst_valid", if_valid, 1'b0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        // cycle after reset edge: still quiet
        rst_n = 1'b1;
        settle;
        chk("post_rst_rom_en", rom_en, 1'b0);
        chk("post_rst_valid", if_valid, 1'b0);
        tick;
        chk("c0_rom_en", rom_en, 1'b1);
        chk("c0_addr", rom_addr, 7'd0);
        chk("c0_valid", if_valid, 1'b0);
        tick;
        chk("c1_rom_en", rom_en, 1'b1);
        chk("c1_addr", rom_addr, 7'd1);
        chk("c1_valid", if_valid, 1'b0);
        tick;
        chk_out("fill0", 32'h0, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk_out("stream", 32'(4 * k), 32'(k));
        end

        // backpressure: hold if_ready low six cycles from the first instruction
        do_reset;
        if_ready = 1'b0;
        tick;
        tick;
        tick;
        chk_out("stall_first", 32'h0, 32'd0);
        repeat (5) tick;
        chk("stall_rom_en", rom_en, 1'b0);
        chk_out("stall_hold", 32'h0, 32'd0);
        tick;
        if_ready = 1'b1;
        settle;
        chk("release_rom_en", rom_en, 1'b1);
        chk_out("release0", 32'h0, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk_out("release", 32'(4 * k), 32'(k));
        end

        // redirect with instruction 2 at head and 3 in flight; low bits must be ignored
        do_reset;
        repeat (5) tick;
        chk_out("pre_redir", 32'h8, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h43;
        settle;
        chk("redir_rom_en", rom_en, 1'b0);
        tick;
        redirect_valid = 1'b0;
        settle;
        chk("redir_t1_valid", if_valid, 1'b0);
        chk("redir_t1_en", rom_en, 1'b1);
        chk("redir_t1_addr", rom_addr, 7'd16);
        tick;
        chk("redir_t2_valid", if_valid, 1'b0);
        tick;
        chk_out("redir_t3", 32'h40, 32'd16);
        tick;
        chk_out("redir_t4", 32'h44, 32'd17);

        // redirect near the top of the ROM: address wraps, PC keeps counting
        redirect_valid = 1'b1;
        redirect_pc = 32'h1FC;
        settle;
        tick;
        redirect_valid = 1'b0;
        settle;
        chk("wrap_addr127", rom_addr, 7'd127);
        chk("wrap_en", rom_en, 1'b1);
        tick;
        chk("wrap_addr0", rom_addr, 7'd0);
        tick;
        chk_out("wrap_a", 32'h1FC, 32'd127);
        tick;
        chk_out("wrap_b", 32'h200, 32'd0);
        tick;
        chk_out("wrap_c", 32'h204, 32'd1);

        // fill the buffer, then reset together with a redirect
        if_ready = 1'b0;
        settle;
        tick;
        tick;
        tick;
        chk("full_rom_en", rom_en, 1'b0);
        chk_out("full_head", 32'h204, 32'd1);
        rst_n = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        if_ready = 1'b1;
        settle;
        chk("midrst_valid", if_valid, 1'b0);
        chk("midrst_en", rom_en, 1'b0);
        tick;
        rst_n = 1'b1;
        redirect_valid = 1'b0;
        settle;
        chk("midrst_n_en", rom_en, 1'b0);
        chk("midrst_n_valid", if_valid, 1'b0);
        chk("midrst_n_instr", if_instr, 32'h0);
        chk("midrst_n_pc", if_pc, 32'h0);
        chk("midrst_n_addr", rom_addr, 7'd0);
        tick;
        chk("restart_en", rom_en, 1'b1);
        tick;
        tick;
        chk_out("restart0", 32'h0, 32'd0);
        tick;
        chk_out("restart1", 32'h4, 32'd1);

        // alternating if_ready: pops at every even cycle from c2, strictly in order
        do_reset;
        tick;
        exp_n = 0;
        for (int k = 0; k < 20; k++) begin
            if_ready = (k % 2 == 0);
            settle;
            if (if_valid && if_ready) begin
                chk("alt_pc", if_pc, 32'(4 * exp_n));
                chk("alt_instr", if_instr, 32'(exp_n));
                exp_n++;
            end
            tick;
        end
        chk("alt_pops", 32'(exp_n), 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
